// File: rtl/zclock_turbo_sched.sv
// ---------------------------------------------------------------------------
// zclock_turbo_sched
//
// Purpose:
//   Schedules changes of the Z80 clock generator's turbo mode. A new mode
//   requested by the CPU, or forced to 3.5 MHz by turbo_lock, is not applied
//   straight away. It is applied only at a refresh-cycle boundary, aligned to
//   the 7 MHz phase-0 strobe. While the change is in progress a stall is held
//   to the clock generator so that no truncated half-period reaches the CPU.
//   If no RFSH edge arrives within RFSH_TIMEOUT clocks, the switch is forced.
//
// Parameters:
//   SETTLE_TACTS  clocks the stall is held after turbo_out changes (1..15)
//   RFSH_TIMEOUT  clocks to wait for an RFSH fall before forcing (1..1023)
//
// Ports:
//   clk             28 MHz system clock
//   rst_n           asynchronous active-low reset
//   c0              7 MHz phase-0 strobe, one clk wide, every 4th clk
//   rfsh_n          Z80 RFSH, already synchronised to clk
//   turbo_req[1:0]  requested mode: 00 = 3.5 MHz, 01 = 7 MHz, 1x = 14 MHz
//   turbo_lock      forces the 3.5 MHz target while high
//   turbo_out[1:0]  mode driven to the clock generator (00/01/10 only)
//   switch_stall    stall request, ORed into the clock generator's cpu_stall
//   switch_pending  high while a switch is waiting, aligning or settling
//   forced_switch   one-clk pulse when a switch is started by the timeout
// ---------------------------------------------------------------------------
module zclock_turbo_sched #(
   parameter int unsigned SETTLE_TACTS = 4,
   parameter int unsigned RFSH_TIMEOUT = 1023
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       c0,
   input  logic       rfsh_n,
   input  logic [1:0] turbo_req,
   input  logic       turbo_lock,
   output logic [1:0] turbo_out,
   output logic       switch_stall,
   output logic       switch_pending,
   output logic       forced_switch
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_ALIGN   = 2'd2,
      ST_SETTLE  = 2'd3
   } state_e;

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_TACTS - 1);
   localparam logic [9:0] TMO_LAST    = 10'(RFSH_TIMEOUT - 1);

   // Registered state
   state_e     state_q,     state_d;
   logic [1:0] turbo_out_q, turbo_out_d;
   logic       stall_q,     stall_d;
   logic       forced_q,    forced_d;
   logic [1:0] target_q,    target_d;
   logic [3:0] settle_q,    settle_d;
   logic [9:0] tmo_q,       tmo_d;
   logic       rfsh_q,      rfsh_d;

   // Combinational helpers
   logic [1:0] tgt_eff;
   logic       rfsh_fall;

   // Effective target: lock wins, and 1x is folded onto the single 14 MHz
   // code 10 so turbo_out never carries 11.
   always_comb begin
      tgt_eff = 2'b00;
      if (!turbo_lock) begin
         tgt_eff = turbo_req[1] ? 2'b10 : {1'b0, turbo_req[0]};
      end
   end

   assign rfsh_fall = rfsh_q & ~rfsh_n;
   assign rfsh_d    = rfsh_n;

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      turbo_out_d = turbo_out_q;
      forced_d    = 1'b0;
      target_d    = target_q;
      settle_d    = settle_q;
      tmo_d       = tmo_q;

      unique case (state_q)
         ST_IDLE: begin
            if (tgt_eff != turbo_out_q) begin
               target_d = tgt_eff;
               tmo_d    = '0;
               state_d  = ST_PENDING;
            end
         end

         ST_PENDING: begin
            // Latest request wins until the switch point is committed.
            target_d = tgt_eff;
            if (tgt_eff == turbo_out_q) begin
               // Cancellation outranks both the RFSH edge and the timeout.
               state_d = ST_IDLE;
            end else if (rfsh_fall) begin
               // A real RFSH edge on the timeout clk is not a forced switch.
               state_d = ST_ALIGN;
            end else if (tmo_q == TMO_LAST) begin
               state_d  = ST_ALIGN;
               forced_d = 1'b1;
            end else if (tmo_q != '1) begin
               tmo_d = tmo_q + 10'd1;
            end
         end

         ST_ALIGN: begin
            // Target is frozen here; only the phase-0 strobe matters.
            if (c0) begin
               turbo_out_d = target_q;
               settle_d    = SETTLE_LOAD;
               state_d     = ST_SETTLE;
            end
         end

         ST_SETTLE: begin
            if (settle_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               settle_d = settle_q - 4'd1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Stall is a registered copy of "next state is ALIGN or SETTLE", so it
      // is already high on the first ALIGN clk and drops on the IDLE clk.
      stall_d = (state_d == ST_ALIGN) || (state_d == ST_SETTLE);
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         turbo_out_q <= 2'b00;
         stall_q     <= 1'b0;
         forced_q    <= 1'b0;
         target_q    <= 2'b00;
         settle_q    <= '0;
         tmo_q       <= '0;
         rfsh_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         turbo_out_q <= turbo_out_d;
         stall_q     <= stall_d;
         forced_q    <= forced_d;
         target_q    <= target_d;
         settle_q    <= settle_d;
         tmo_q       <= tmo_d;
         rfsh_q      <= rfsh_d;
      end
   end

   assign turbo_out      = turbo_out_q;
   assign switch_stall   = stall_q;
   assign forced_switch  = forced_q;
   assign switch_pending = (state_q != ST_IDLE);

   // Invariants of the registered outputs
   a_no_mode_11 : assert property (@(posedge clk) disable iff (!rst_n)
      turbo_out_q != 2'b11);
   a_stall_in_switch : assert property (@(posedge clk) disable iff (!rst_n)
      stall_q |-> (state_q == ST_ALIGN || state_q == ST_SETTLE));

endmodule
